// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decodes the RISC-V immediate, format and PC-relative
// target of each accepted instruction and holds it in a two-entry skid buffer.
module imm_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    // Buffer occupancy encoded as {skid_v, main_v}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_TWO   = 2'b11;

    typedef struct packed {
        logic [31:0]     inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } entry_t;

    entry_t dec_entry;
    entry_t main_reg;
    entry_t skid_reg;
    logic   main_v_reg;
    logic   skid_v_reg;

    logic [4:0]      opcode;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_z;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_rel;
    logic            accept;
    logic            consume;

    assign opcode = in_inst[6:2];

    // Signed size-casts give the sign extension to XLEN for every format.
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_z = XLEN'(in_inst[19:15]);

    always_comb begin
        dec_fmt = FMT_ILL;
        dec_imm = '0;
        dec_rel = 1'b0;
        if (in_inst[1:0] == 2'b11) begin
            case (opcode)
                5'b00000, 5'b00011, 5'b00100, 5'b11001: begin dec_fmt = FMT_I; dec_imm = imm_i; end
                5'b01000: begin dec_fmt = FMT_S;   dec_imm = imm_s; end
                5'b11000: begin dec_fmt = FMT_B;   dec_imm = imm_b; dec_rel = 1'b1; end
                5'b01101: begin dec_fmt = FMT_U;   dec_imm = imm_u; end
                5'b00101: begin dec_fmt = FMT_U;   dec_imm = imm_u; dec_rel = 1'b1; end
                5'b11011: begin dec_fmt = FMT_J;   dec_imm = imm_j; dec_rel = 1'b1; end
                5'b11100: begin dec_fmt = FMT_CSR; dec_imm = imm_z; end
                5'b01100: dec_fmt = FMT_R;
                5'b00110: if (XLEN == 64) begin dec_fmt = FMT_I; dec_imm = imm_i; end
                5'b01110: if (XLEN == 64) dec_fmt = FMT_R;
                default: ;
            endcase
        end
    end

    // JALR also gets pc+4: its base register is not known at this stage.
    always_comb begin
        dec_entry         = '0;
        dec_entry.inst    = in_inst;
        dec_entry.pc      = in_pc;
        dec_entry.imm     = dec_imm;
        dec_entry.target  = in_pc + (dec_rel ? dec_imm : XLEN'(4));
        dec_entry.fmt     = dec_fmt;
        dec_entry.illegal = (dec_fmt == FMT_ILL);
    end

    assign accept  = in_valid & in_ready;
    assign consume = main_v_reg & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_reg   <= '0;
            skid_reg   <= '0;
            main_v_reg <= 1'b0;
            skid_v_reg <= 1'b0;
        end else if (flush) begin
            main_v_reg <= 1'b0;
            skid_v_reg <= 1'b0;
        end else begin
            case ({skid_v_reg, main_v_reg})
                ST_EMPTY: begin
                    if (accept) begin
                        main_reg   <= dec_entry;
                        main_v_reg <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_reg <= dec_entry;
                    end else if (accept) begin
                        skid_reg   <= dec_entry;
                        skid_v_reg <= 1'b1;
                    end else if (consume) begin
                        main_v_reg <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        main_reg   <= skid_reg;
                        skid_v_reg <= 1'b0;
                    end
                end
                default: begin
                    main_v_reg <= 1'b0;
                    skid_v_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = ~skid_v_reg;
    assign out_valid   = main_v_reg;
    assign out_inst    = main_reg.inst;
    assign out_pc      = main_reg.pc;
    assign out_imm     = main_reg.imm;
    assign out_target  = main_reg.target;
    assign out_fmt     = main_reg.fmt;
    assign out_illegal = main_reg.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: one XLEN=32 and one XLEN=64 instance, directed
// vectors with hand-computed expectations, backpressure, flush and mid-operation reset.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [31:0] out_target;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    logic        in_valid64 = 1'b0;
    logic        in_ready64;
    logic [31:0] in_inst64 = '0;
    logic [63:0] in_pc64 = '0;
    logic        out_valid64;
    logic        out_ready64 = 1'b1;
    logic [31:0] out_inst64;
    logic [63:0] out_pc64;
    logic [63:0] out_imm64;
    logic [63:0] out_target64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm),
        .out_target(out_target), .out_fmt(out_fmt), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_inst(in_inst64), .in_pc(in_pc64), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready64), .out_inst(out_inst64), .out_pc(out_pc64), .out_imm(out_imm64),
        .out_target(out_target64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input exp_t e, input logic [31:0] inst,
                             input logic [63:0] pc, input logic [63:0] imm,
                             input logic [63:0] tgt, input logic [2:0] fmt, input logic ill);
        chk({tag, "_inst"}, {32'b0, inst}, {32'b0, e.inst});
        chk({tag, "_pc"}, pc, e.pc);
        chk({tag, "_imm"}, imm, e.imm);
        chk({tag, "_target"}, tgt, e.tgt);
        chk({tag, "_fmt"}, {61'b0, fmt}, {61'b0, e.fmt});
        chk({tag, "_illegal"}, {63'b0, ill}, {63'b0, e.fmt == 3'd7});
    endtask

    // Scoreboard pop: every handshake at the output is matched against the oldest push.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            chk("out32_expected_any", {63'b0, q32.size() != 0}, 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                $display("txn32 inst=%h pc=%h imm=%h target=%h fmt=%0d", out_inst, out_pc,
                         out_imm, out_target, out_fmt);
                cmp_entry("x32", e, out_inst, {32'b0, out_pc}, {32'b0, out_imm},
                          {32'b0, out_target}, out_fmt, out_illegal);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid64 && out_ready64) begin
            exp_t e;
            chk("out64_expected_any", {63'b0, q64.size() != 0}, 64'd1);
            if (q64.size() != 0) begin
                e = q64.pop_front();
                $display("txn64 inst=%h pc=%h imm=%h target=%h fmt=%0d", out_inst64, out_pc64,
                         out_imm64, out_target64, out_fmt64);
                cmp_entry("x64", e, out_inst64, out_pc64, out_imm64, out_target64,
                          out_fmt64, out_illegal64);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the entry.
    task automatic send(input bit w64, input logic [31:0] inst, input logic [63:0] pc,
                        input logic [63:0] imm, input logic [63:0] tgt, input logic [2:0] fmt);
        exp_t e;
        bit   done = 1'b0;
        e.inst = inst; e.pc = pc; e.imm = imm; e.tgt = tgt; e.fmt = fmt;
        if (w64) begin
            in_valid64 = 1'b1; in_inst64 = inst; in_pc64 = pc;
        end else begin
            in_valid = 1'b1; in_inst = inst; in_pc = pc[31:0];
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (w64 ? in_ready64 : in_ready) begin
                if (w64) q64.push_back(e); else q32.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_accept_timeout", 64'd0, 64'd1);
        in_valid   = 1'b0;
        in_valid64 = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clk);
        chk({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        chk({tag, "_in_ready"}, {63'b0, in_ready}, 64'd1);
        chk({tag, "_out_inst"}, {32'b0, out_inst}, 64'd0);
        chk({tag, "_out_pc"}, {32'b0, out_pc}, 64'd0);
        chk({tag, "_out_imm"}, {32'b0, out_imm}, 64'd0);
        chk({tag, "_out_target"}, {32'b0, out_target}, 64'd0);
        chk({tag, "_out_fmt"}, {61'b0, out_fmt}, 64'd0);
        chk({tag, "_out_illegal"}, {63'b0, out_illegal}, 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("reset");
        chk("reset64_out_valid", {63'b0, out_valid64}, 64'd0);
        chk("reset64_in_ready", {63'b0, in_ready64}, 64'd1);
        @(posedge clk);
        #1;

        // Back-to-back decode vectors with the consumer always ready.
        out_ready = 1'b1;
        send(0, 32'hFFF00093, 64'h100, 64'hFFFFFFFF, 64'h104, 3'd1);
        send(0, 32'hFE000EE3, 64'h100, 64'hFFFFFFFC, 64'hFC, 3'd3);
        send(0, 32'h0080006F, 64'h200, 64'h8, 64'h208, 3'd5);
        send(0, 32'h00000000, 64'h300, 64'h0, 64'h304, 3'd7);
        send(0, 32'h00512623, 64'h400, 64'hC, 64'h404, 3'd2);
        send(0, 32'h12345097, 64'h10, 64'h12345000, 64'h12345010, 3'd4);
        send(0, 32'h340F9073, 64'h20, 64'h1F, 64'h24, 3'd6);
        send(0, 32'h002081B3, 64'h30, 64'h0, 64'h34, 3'd0);
        send(0, 32'h0080006F, 64'hFFFFFFFC, 64'h8, 64'h4, 3'd5);
        send(0, 32'h00000092, 64'h40, 64'h0, 64'h44, 3'd7);
        send(0, 32'h0000001B, 64'h50, 64'h0, 64'h54, 3'd7);
        send(1, 32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 64'h4, 3'd4);
        send(1, 32'h0000001B, 64'h60, 64'h0, 64'h64, 3'd1);
        send(1, 32'h002081BB, 64'h70, 64'h0, 64'h74, 3'd0);
        send(1, 32'hFFFFF097, 64'h1000, 64'hFFFFFFFFFFFFF000, 64'h0, 3'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("drain_q32", q32.size(), 64'd0);
        chk("drain_q64", q64.size(), 64'd0);

        // Backpressure: A fills main, B fills skid, C must wait upstream.
        out_ready = 1'b0;
        send(0, 32'h00100093, 64'h500, 64'h1, 64'h504, 3'd1);
        send(0, 32'h00200113, 64'h504, 64'h2, 64'h508, 3'd1);
        in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 32'h508;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        chk("bp_out_valid", {63'b0, out_valid}, 64'd1);
        chk("bp_main_holds_a", {32'b0, out_inst}, 64'h00100093);
        chk("bp_pending", q32.size(), 64'd2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        send(0, 32'h00300193, 64'h508, 64'h3, 64'h50C, 3'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_drain", q32.size(), 64'd0);

        // Flush while full, with a simultaneous incoming entry that must be dropped.
        out_ready = 1'b0;
        send(0, 32'h00400213, 64'h600, 64'h4, 64'h604, 3'd1);
        send(0, 32'h00500293, 64'h604, 64'h5, 64'h608, 3'd1);
        q32.delete();
        in_valid = 1'b1; in_inst = 32'h00600313; in_pc = 32'h608;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {63'b0, out_valid}, 64'd0);
        chk("flush_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset pulse while full clears state and data registers.
        out_ready = 1'b0;
        send(0, 32'h00700393, 64'h700, 64'h7, 64'h704, 3'd1);
        send(0, 32'h00800413, 64'h704, 64'h8, 64'h708, 3'd1);
        q32.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_cleared("midrst");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("final_q32", q32.size(), 64'd0);
        chk("final_q64", q64.size(), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
